connect4_board_engine: RTL and testbench
========================================

Name: connect4_board_engine

Overview:
- Move/board engine feeding the Connect-4 game FSM: accepts column drops, stores the 6x7 board and places pieces by gravity.
- Scans for a 4-in-a-row through the newest piece and reports through invalid_move, in_game_status, player_turn and board_full.
- Takes current_state back from the FSM to gate moves.
- Exposes a read port for the display/VGA logic.

Parameters:
- ROWS, 6, board rows; row 0 is the bottom.
- COLS, 7, board columns; column 0 is the left.
- WIN_LEN, 4, run length that wins.
- ROWS and COLS must each be ≤ 8 (3-bit indices).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high; clears the board and all state.
- move_valid  in  1  one-cycle drop request.
- move_col  in  3  requested column.
- current_state  in  2  FSM state: 00 INIT, 01 P1_TURN, 10 END, 11 P2_TURN.
- invalid_move  out  1  one-cycle pulse when a drop is rejected.
- in_game_status  out  2  00 NEXT_TURN, 01 PLAYER_WIN, 10 TIE_GAME.
- player_turn  out  1  toggles once per completed move; 0 means P1 to play.
- board_full  out  1  board filled with no win.
- busy  out  1  high from acceptance until the outputs update.
- rd_row  in  3  display read row.
- rd_col  in  3  display read column.
- rd_cell  out  2  combinational cell value: 00 empty, 01 P1, 10 P2; 00 if the address is out of range.

Behaviour:
- Reset values: all cells 00, all column heights 0, piece count 0. invalid_move=0, in_game_status=00, player_turn=0, board_full=0, busy=0. State is IDLE.
- Reset wins over every other event, including mid-scan; the move in progress is discarded.
- States: IDLE, PLACE, SCAN, REPORT.
- IDLE, move acceptance. All of the following must hold:
  - move_valid=1;
  - current_state is 01 with player_turn=0, or 11 with player_turn=1.
  - Otherwise the request is silently ignored: no pulse, no state change.
- IDLE, rejection. If move_col ≥ COLS or height[move_col]==ROWS:
  - invalid_move=1 on the next cycle for exactly one cycle;
  - board, player_turn and in_game_status unchanged;
  - stay in IDLE.
- IDLE, legal drop: latch col and player (P1 if current_state=01); busy=1 from the next cycle; go to PLACE.
- PLACE (1 cycle):
  - write the player code at (height[col], col);
  - latch row=height[col];
  - height[col]+1, count+1;
  - go to SCAN.
- SCAN, one cell read per cycle. Directions in order: horizontal (0,+1), vertical (+1,0), diagonal (+1,+1), anti-diagonal (+1,-1).
  - For each direction, walk the positive side, then the negative side, steps 1..WIN_LEN-1.
  - A side ends at the first off-board coordinate (signed compare, no wrap) or the first non-matching cell; that cycle counts toward the scan.
  - run = 1 + matches on both sides. run ≥ WIN_LEN means a win and goes to REPORT immediately.
  - After the last direction without a win, go to REPORT.
  - Worst case is 4·2·(WIN_LEN-1) = 24 cycles.
- REPORT (1 cycle). On the edge leaving REPORT:
  - win: in_game_status=01, board_full=0, even if count==ROWS·COLS;
  - count==ROWS·COLS and no win: in_game_status=10, board_full=1;
  - otherwise: in_game_status=00;
  - in all cases: player_turn toggles, busy=0, return to IDLE.
  - All of these outputs change on the same edge.
- Outputs hold until the next REPORT or reset.
- Worst-case latency from move_valid to the output update is 27 edges.
- move_valid while busy is ignored.
- Drops in END (10) or INIT (00) are ignored.
- board_full and a win are mutually exclusive, so the FSM's board_full-first priority cannot turn a last-piece win into a tie.

Decomposition:
- Shared package connect4_pkg holds:
  - FSM state codes: GAME_INIT, P1_TURN, END_GAME, P2_TURN;
  - status codes: NEXT_TURN, PLAYER_WIN, TIE_GAME;
  - cell codes: EMPTY, P1, P2;
  - direction delta constants.
- Sub-module connect4_run_scanner holds the SCAN counters: direction, side, step, run. Its interface:
  - inputs: start, origin row/col, player, cell read data;
  - outputs: read address, done, win.

Test Plan:
- Reset; current_state=01, drop col 3 → cell(0,3)=01, height[3]=1, player_turn 0→1, in_game_status=00, invalid_move=0.
- P1 col0, P2 col1 ×3 each, then P1 col0 (4th) → vertical win; in_game_status=01 and player_turn toggles on the same edge; rd_cell(3,0)=01.
- Six drops into col 2, then a 7th drop into col 2 → invalid_move high exactly 1 cycle; player_turn and cells unchanged. move_col=7 → invalid pulse.
- Horizontal run cols 3–6 → win, with no wrap into col 0. Anti-diagonal completed by a middle piece (runs 2+1) → win.
- Fill all 42 cells with no win → last REPORT gives board_full=1, in_game_status=10. Variant where the 42nd piece wins → board_full=0, in_game_status=01.
- Each of the following is ignored, with no pulse:
  - reset asserted mid-SCAN → all outputs and cells return to reset values;
  - move_valid while busy;
  - move_valid with current_state=10;
  - move_valid with current_state=01 and player_turn=1.

Source files
------------

// File: rtl/connect4_pkg.sv
// rtl/connect4_pkg.sv - shared codes and direction deltas for the Connect-4 board engine
package connect4_pkg;

    // Game FSM state codes seen on current_state
    localparam logic [1:0] GAME_INIT = 2'b00;
    localparam logic [1:0] P1_TURN   = 2'b01;
    localparam logic [1:0] END_GAME  = 2'b10;
    localparam logic [1:0] P2_TURN   = 2'b11;

    // in_game_status codes
    localparam logic [1:0] NEXT_TURN  = 2'b00;
    localparam logic [1:0] PLAYER_WIN = 2'b01;
    localparam logic [1:0] TIE_GAME   = 2'b10;

    // Cell contents
    localparam logic [1:0] EMPTY = 2'b00;
    localparam logic [1:0] P1    = 2'b01;
    localparam logic [1:0] P2    = 2'b10;

    // Scan directions, in scan order
    localparam logic [1:0] DIR_HORZ = 2'd0;
    localparam logic [1:0] DIR_VERT = 2'd1;
    localparam logic [1:0] DIR_DIAG = 2'd2;
    localparam logic [1:0] DIR_ANTI = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PLACE,
        ST_SCAN,
        ST_REPORT
    } engine_state_t;

    // Positive-side row delta of a direction
    function automatic logic signed [4:0] dir_drow(input logic [1:0] dir);
        return (dir == DIR_HORZ) ? 5'sd0 : 5'sd1;
    endfunction

    // Positive-side column delta of a direction
    function automatic logic signed [4:0] dir_dcol(input logic [1:0] dir);
        case (dir)
            DIR_HORZ, DIR_DIAG: return 5'sd1;
            DIR_VERT:           return 5'sd0;
            default:            return -5'sd1;
        endcase
    endfunction

endpackage

// File: rtl/connect4_run_scanner.sv
// rtl/connect4_run_scanner.sv - walks the four lines through the newest piece looking for a winning run
// Ports: clk/reset; start latches origin_row/origin_col/player; rd_row/rd_col address the
// cell whose contents come back combinationally on rd_data; done (with win) marks the last scan cycle.
module connect4_run_scanner #(
    parameter int ROWS    = 6,
    parameter int COLS    = 7,
    parameter int WIN_LEN = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [2:0] origin_row,
    input  logic [2:0] origin_col,
    input  logic [1:0] player,
    input  logic [1:0] rd_data,
    output logic [2:0] rd_row,
    output logic [2:0] rd_col,
    output logic       done,
    output logic       win
);
    import connect4_pkg::*;

    logic              active;
    logic              side;      // 0: positive side, 1: negative side
    logic [1:0]        dir;
    logic [3:0]        step;
    logic [3:0]        run;
    logic [1:0]        player_q;
    logic signed [4:0] org_r, org_c;
    logic signed [4:0] cur_r, cur_c;

    logic signed [4:0] step_dr, step_dc;
    logic              in_board, match, hit_win, side_end, last_cell;
    logic [3:0]        run_inc;
    logic [1:0]        dir_nxt;

    always_comb begin
        step_dr   = side ? -dir_drow(dir) : dir_drow(dir);
        step_dc   = side ? -dir_dcol(dir) : dir_dcol(dir);
        // Signed coordinates so stepping left of column 0 is off-board rather than wrapping
        in_board  = !cur_r[4] && !cur_c[4] &&
                    (cur_r[3:0] < 4'(ROWS)) && (cur_c[3:0] < 4'(COLS));
        match     = in_board && (rd_data == player_q);
        run_inc   = run + 4'd1;
        hit_win   = match && (run_inc >= 4'(WIN_LEN));
        side_end  = !match || (step == 4'(WIN_LEN - 1));
        last_cell = side_end && side && (dir == DIR_ANTI);
        dir_nxt   = dir + 2'd1;
    end

    assign done   = active && (hit_win || last_cell);
    assign win    = active && hit_win;
    assign rd_row = cur_r[2:0];
    assign rd_col = cur_c[2:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            active   <= 1'b0;
            side     <= 1'b0;
            dir      <= DIR_HORZ;
            step     <= '0;
            run      <= '0;
            player_q <= EMPTY;
            org_r    <= '0;
            org_c    <= '0;
            cur_r    <= '0;
            cur_c    <= '0;
        end else if (start) begin
            active   <= 1'b1;
            side     <= 1'b0;
            dir      <= DIR_HORZ;
            step     <= 4'd1;
            run      <= 4'd1;
            player_q <= player;
            org_r    <= $signed({2'b00, origin_row});
            org_c    <= $signed({2'b00, origin_col});
            cur_r    <= $signed({2'b00, origin_row}) + dir_drow(DIR_HORZ);
            cur_c    <= $signed({2'b00, origin_col}) + dir_dcol(DIR_HORZ);
        end else if (active) begin
            if (done) begin
                active <= 1'b0;
            end else if (!side_end) begin
                step  <= step + 4'd1;
                run   <= run_inc;
                cur_r <= cur_r + step_dr;
                cur_c <= cur_c + step_dc;
            end else if (!side) begin
                // Same direction, now walk away from the origin the other way
                side  <= 1'b1;
                step  <= 4'd1;
                run   <= match ? run_inc : run;
                cur_r <= org_r - dir_drow(dir);
                cur_c <= org_c - dir_dcol(dir);
            end else begin
                dir   <= dir_nxt;
                side  <= 1'b0;
                step  <= 4'd1;
                run   <= 4'd1;
                cur_r <= org_r + dir_drow(dir_nxt);
                cur_c <= org_c + dir_dcol(dir_nxt);
            end
        end
    end

endmodule

// File: rtl/connect4_board_engine.sv
// rtl/connect4_board_engine.sv - Connect-4 board store, gravity drop and win/tie detection
// Ports: clk/reset; move_valid/move_col drop request gated by current_state and player_turn;
// invalid_move, in_game_status, player_turn, board_full, busy report results;
// rd_row/rd_col/rd_cell form the combinational display read port.
module connect4_board_engine #(
    parameter int ROWS    = 6,
    parameter int COLS    = 7,
    parameter int WIN_LEN = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       move_valid,
    input  logic [2:0] move_col,
    input  logic [1:0] current_state,
    output logic       invalid_move,
    output logic [1:0] in_game_status,
    output logic       player_turn,
    output logic       board_full,
    output logic       busy,
    input  logic [2:0] rd_row,
    input  logic [2:0] rd_col,
    output logic [1:0] rd_cell
);
    import connect4_pkg::*;

    localparam logic [6:0] CELLS = 7'(ROWS * COLS);

    engine_state_t state;
    logic [1:0]    board  [ROWS][COLS];
    logic [3:0]    height [COLS];
    logic [6:0]    count;
    logic [2:0]    col_q;
    logic [1:0]    player_q;
    logic          win_q;

    logic          move_ok, col_ok;
    logic [3:0]    sel_height;
    logic [2:0]    scan_row, scan_col;
    logic [1:0]    scan_cell;
    logic          scan_done, scan_win;

    // Only the player whose turn it is may drop
    assign move_ok = move_valid &&
                     (((current_state == P1_TURN) && !player_turn) ||
                      ((current_state == P2_TURN) &&  player_turn));
    assign col_ok  = ({1'b0, move_col} < 4'(COLS));

    // Height lookup that stays in range for an illegal column
    always_comb begin
        sel_height = '0;
        for (int c = 0; c < COLS; c++) begin
            if (move_col == 3'(c)) begin
                sel_height = height[c];
            end
        end
    end

    always_comb begin
        rd_cell = EMPTY;
        if (({1'b0, rd_row} < 4'(ROWS)) && ({1'b0, rd_col} < 4'(COLS))) begin
            rd_cell = board[rd_row][rd_col];
        end
    end

    always_comb begin
        scan_cell = EMPTY;
        if (({1'b0, scan_row} < 4'(ROWS)) && ({1'b0, scan_col} < 4'(COLS))) begin
            scan_cell = board[scan_row][scan_col];
        end
    end

    // Origin is the landing row, read before the PLACE-edge increment of height
    connect4_run_scanner #(
        .ROWS    (ROWS),
        .COLS    (COLS),
        .WIN_LEN (WIN_LEN)
    ) u_scanner (
        .clk        (clk),
        .reset      (reset),
        .start      (state == ST_PLACE),
        .origin_row (height[col_q][2:0]),
        .origin_col (col_q),
        .player     (player_q),
        .rd_data    (scan_cell),
        .rd_row     (scan_row),
        .rd_col     (scan_col),
        .done       (scan_done),
        .win        (scan_win)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ST_IDLE;
            invalid_move   <= 1'b0;
            in_game_status <= NEXT_TURN;
            player_turn    <= 1'b0;
            board_full     <= 1'b0;
            busy           <= 1'b0;
            count          <= '0;
            col_q          <= '0;
            player_q       <= EMPTY;
            win_q          <= 1'b0;
            for (int c = 0; c < COLS; c++) begin
                height[c] <= '0;
                for (int r = 0; r < ROWS; r++) begin
                    board[r][c] <= EMPTY;
                end
            end
        end else begin
            invalid_move <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (move_ok) begin
                        if (!col_ok || (sel_height == 4'(ROWS))) begin
                            invalid_move <= 1'b1;
                        end else begin
                            col_q    <= move_col;
                            player_q <= (current_state == P1_TURN) ? P1 : P2;
                            busy     <= 1'b1;
                            state    <= ST_PLACE;
                        end
                    end
                end
                ST_PLACE: begin
                    board[height[col_q][2:0]][col_q] <= player_q;
                    height[col_q] <= height[col_q] + 4'd1;
                    count         <= count + 7'd1;
                    state         <= ST_SCAN;
                end
                ST_SCAN: begin
                    if (scan_done) begin
                        win_q <= scan_win;
                        state <= ST_REPORT;
                    end
                end
                ST_REPORT: begin
                    // A win on the last piece must not read as a tie
                    if (win_q) begin
                        in_game_status <= PLAYER_WIN;
                        board_full     <= 1'b0;
                    end else if (count == CELLS) begin
                        in_game_status <= TIE_GAME;
                        board_full     <= 1'b1;
                    end else begin
                        in_game_status <= NEXT_TURN;
                        board_full     <= 1'b0;
                    end
                    player_turn <= ~player_turn;
                    busy        <= 1'b0;
                    state       <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_connect4_board_engine.sv
// tb/tb_connect4_board_engine.sv - randomized and directed checks of connect4_board_engine against a board model
module tb_connect4_board_engine;
    import connect4_pkg::*;

    localparam int ROWS    = 6;
    localparam int COLS    = 7;
    localparam int WIN_LEN = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       move_valid;
    logic [2:0] move_col;
    logic [1:0] current_state;
    logic       invalid_move;
    logic [1:0] in_game_status;
    logic       player_turn;
    logic       board_full;
    logic       busy;
    logic [2:0] rd_row;
    logic [2:0] rd_col;
    logic [1:0] rd_cell;

    connect4_board_engine #(
        .ROWS    (ROWS),
        .COLS    (COLS),
        .WIN_LEN (WIN_LEN)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .move_valid     (move_valid),
        .move_col       (move_col),
        .current_state  (current_state),
        .invalid_move   (invalid_move),
        .in_game_status (in_game_status),
        .player_turn    (player_turn),
        .board_full     (board_full),
        .busy           (busy),
        .rd_row         (rd_row),
        .rd_col         (rd_col),
        .rd_cell        (rd_cell)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: plain board of player numbers (0 empty, 1 P1, 2 P2)
    int mb [ROWS][COLS];
    int m_turn, m_status, m_full, m_count;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic void m_reset();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                mb[r][c] = 0;
        m_turn = 0; m_status = 0; m_full = 0; m_count = 0;
    endfunction

    function automatic int m_height(input int c);
        int h = 0;
        for (int r = 0; r < ROWS; r++)
            if (mb[r][c] != 0) h = r + 1;
        return h;
    endfunction

    function automatic int m_line(input int r, input int c, input int dr, input int dc, input int p);
        int n = 0;
        int rr = r + dr;
        int cc = c + dc;
        while (rr >= 0 && rr < ROWS && cc >= 0 && cc < COLS && mb[rr][cc] == p) begin
            n++; rr += dr; cc += dc;
        end
        return n;
    endfunction

    function automatic bit m_wins(input int r, input int c, input int p);
        int dr [4] = '{0, 1, 1, 1};
        int dc [4] = '{1, 0, 1, -1};
        for (int d = 0; d < 4; d++)
            if (1 + m_line(r, c, dr[d], dc[d], p) + m_line(r, c, -dr[d], -dc[d], p) >= WIN_LEN)
                return 1'b1;
        return 1'b0;
    endfunction

    task automatic check_all(input string tag);
        int bad;
        logic [1:0] exp;
        check({tag, "_status"}, 32'(in_game_status), 32'(m_status));
        check({tag, "_turn"},   32'(player_turn),    32'(m_turn));
        check({tag, "_full"},   32'(board_full),     32'(m_full));
        check({tag, "_busy"},   32'(busy),           32'd0);
        check({tag, "_inv"},    32'(invalid_move),   32'd0);
        bad = 0;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                rd_row = 3'(r); rd_col = 3'(c);
                #1;
                exp = (r < ROWS && c < COLS) ? 2'(mb[r][c]) : 2'b00;
                if (rd_cell !== exp) bad++;
            end
        end
        check({tag, "_board"}, 32'(bad), 32'd0);
    endtask

    task automatic drop(input string tag, input int col, input logic [1:0] cs, input bit poke);
        bit legal_req, w, turn_held, status_held, inv_seen;
        int h, p, lat;
        @(negedge clk);
        move_valid = 1'b1; move_col = 3'(col); current_state = cs;
        legal_req = (cs == P1_TURN && m_turn == 0) || (cs == P2_TURN && m_turn == 1);
        @(negedge clk);
        move_valid = 1'b0;
        if (!legal_req) begin
            check({tag, "_ign_inv"},  32'(invalid_move), 32'd0);
            check({tag, "_ign_busy"}, 32'(busy), 32'd0);
            @(negedge clk);
        end else if (col >= COLS || m_height(col) == ROWS) begin
            check({tag, "_rej_pulse"}, 32'(invalid_move), 32'd1);
            check({tag, "_rej_busy"},  32'(busy), 32'd0);
            @(negedge clk);
            check({tag, "_rej_once"},  32'(invalid_move), 32'd0);
        end else begin
            check({tag, "_acc_busy"}, 32'(busy), 32'd1);
            h = m_height(col);
            p = (cs == P1_TURN) ? 1 : 2;
            mb[h][col] = p;
            m_count++;
            w = m_wins(h, col, p);
            lat = 1; turn_held = 1; status_held = 1; inv_seen = 0;
            while (busy === 1'b1 && lat < 40) begin
                if (player_turn !== 1'(m_turn)) turn_held = 0;
                if (in_game_status !== 2'(m_status)) status_held = 0;
                if (invalid_move !== 1'b0) inv_seen = 1;
                if (poke && lat == 3) begin
                    move_valid = 1'b1; move_col = 3'($urandom_range(0, 7));
                end
                @(negedge clk);
                move_valid = 1'b0;
                lat++;
            end
            check({tag, "_latency_ok"}, 32'(lat <= 27), 32'd1);
            check({tag, "_turn_held"}, 32'(turn_held), 32'd1);
            check({tag, "_stat_held"}, 32'(status_held), 32'd1);
            check({tag, "_no_inv"}, 32'(inv_seen), 32'd0);
            m_status = w ? 1 : ((m_count == ROWS * COLS) ? 2 : 0);
            m_full   = (!w && m_count == ROWS * COLS) ? 1 : 0;
            m_turn   = 1 - m_turn;
        end
        check_all(tag);
    endtask

    task automatic play(input string tag, input int col, input bit poke);
        drop(tag, col, (m_turn != 0) ? P2_TURN : P1_TURN, poke);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; move_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        m_reset();
    endtask

    int anti_seq [11] = '{4, 1, 6, 2, 2, 1, 2, 1, 1, 3, 3};
    int row_ord  [7]  = '{0, 2, 1, 3, 4, 6, 5};
    int last_ord [7]  = '{2, 0, 3, 1, 5, 6, 4};

    initial begin
        reset = 1'b1; move_valid = 1'b0; move_col = '0; current_state = GAME_INIT;
        rd_row = '0; rd_col = '0;
        m_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check_all("reset");

        // First drop lands at the bottom of column 3
        play("first", 3, 1'b0);
        check("first_turn", 32'(player_turn), 32'd1);
        // P1 request while it is P2's turn is ignored
        drop("wrong_player", 4, P1_TURN, 1'b0);
        // Second piece in column 3 sits on row 1
        play("stack", 3, 1'b1);

        // Vertical win
        do_reset();
        for (int i = 0; i < 3; i++) begin
            play("vert", 0, 1'b0);
            play("vert", 1, 1'b0);
        end
        play("vert_last", 0, 1'b0);
        check("vert_win", 32'(in_game_status), 32'(PLAYER_WIN));
        rd_row = 3'd3; rd_col = 3'd0; #1;
        check("vert_cell", 32'(rd_cell), 32'(P1));
        drop("end_state", 2, END_GAME, 1'b0);

        // Column full and out-of-range column
        do_reset();
        for (int i = 0; i < ROWS; i++) play("col2", 2, 1'b0);
        play("col2_full", 2, 1'b0);
        play("col7", 7, 1'b0);

        // Horizontal win at the right edge
        do_reset();
        for (int c = 3; c < 6; c++) begin
            play("horz", c, 1'b1);
            play("horz", c, 1'b0);
        end
        play("horz_last", 6, 1'b0);
        check("horz_win", 32'(in_game_status), 32'(PLAYER_WIN));

        // Anti-diagonal completed by an inner piece
        do_reset();
        foreach (anti_seq[i]) play("anti", anti_seq[i], 1'b0);
        check("anti_win", 32'(in_game_status), 32'(PLAYER_WIN));

        // Full board, no win
        do_reset();
        for (int r = 0; r < ROWS; r++)
            foreach (row_ord[i]) play("tie", row_ord[i], 1'b0);
        check("tie_status", 32'(in_game_status), 32'(TIE_GAME));
        check("tie_full", 32'(board_full), 32'd1);

        // Full board where the last piece wins
        do_reset();
        for (int r = 0; r < ROWS - 1; r++)
            foreach (row_ord[i]) play("w42", row_ord[i], 1'b0);
        foreach (last_ord[i]) play("w42", last_ord[i], 1'b0);
        check("w42_status", 32'(in_game_status), 32'(PLAYER_WIN));
        check("w42_full", 32'(board_full), 32'd0);

        // Reset during the scan discards the move
        do_reset();
        play("pre_mid", 5, 1'b0);
        @(negedge clk);
        move_valid = 1'b1; move_col = 3'd3; current_state = P2_TURN;
        @(negedge clk);
        move_valid = 1'b0;
        check("mid_busy", 32'(busy), 32'd1);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_reset();
        check_all("mid_reset");
        play("post_mid", 3, 1'b0);

        // Random games
        for (int g = 0; g < 4; g++) begin
            do_reset();
            for (int k = 0; k < 50 && m_status == 0; k++) begin
                int sel;
                logic [1:0] cs;
                sel = int'($urandom_range(0, 9));
                if (sel == 0)      cs = END_GAME;
                else if (sel == 1) cs = (m_turn != 0) ? P1_TURN : P2_TURN;
                else               cs = (m_turn != 0) ? P2_TURN : P1_TURN;
                drop("rnd", int'($urandom_range(0, 7)), cs, (sel == 2));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached, tests %0d failed %0d", tests, fails);
        $fatal(1);
    end

endmodule
